in_port_buffer: RTL and testbench
=================================

IN_PORT_BUFFER -- requirements
Module: in_port_buffer

Interface
REQ-001 Parameter WORD_W, default 32: data width of every word held and driven.
REQ-002 Parameter DEPTH, default 4: FIFO entries, power of two >= 2.
REQ-003 Port clock, input, 1: single clock; all state updates on rising edge.
REQ-004 Port clear, input, 1: reset; synchronous and active-high.
REQ-005 Port dev_data, input, WORD_W: word offered by the external input device.
REQ-006 Port dev_valid, input, 1: dev_data is valid this cycle.
REQ-007 Port dev_ready, output, 1: buffer accepts a word this cycle.
REQ-008 Port in_pop, input, 1: CPU consumes the head word (asserted in the cycle InPort is gated onto the bus).
REQ-009 Port BusMuxIn_InPort, output, WORD_W: head word, feeding the bus multiplexer InPort leg.
REQ-010 Port in_empty, output, 1: no words held.
REQ-011 Port in_full, output, 1: DEPTH words held.
REQ-012 Port in_count, output, clog2(DEPTH)+1: words held, 0..DEPTH.
REQ-013 Port underflow, output, 1: sticky; pop attempted while empty.
REQ-014 Port status_clr, input, 1: clears underflow.

Function
REQ-015 Push occurs when dev_valid && dev_ready; word written at write pointer, write pointer increments modulo DEPTH.
REQ-016 dev_ready SHALL equal !in_full, combinational from registered count; no push ever accepted while full, even with simultaneous in_pop.
REQ-017 Pop occurs when in_pop && !in_empty; read pointer increments modulo DEPTH.
REQ-018 in_pop while in_empty: ignored (no pointer/count change), underflow set next edge, even if a push occurs the same cycle.
REQ-019 Simultaneous push and pop (non-empty, non-full): both performed, in_count unchanged.
REQ-020 in_count: +1 on push only, -1 on pop only, unchanged otherwise; never exceeds DEPTH or falls below 0.
REQ-021 in_empty = (in_count == 0); in_full = (in_count == DEPTH); both derived from registered count.
REQ-022 BusMuxIn_InPort SHALL be first-word-fall-through: storage entry at read pointer whenever !in_empty; all-zero when in_empty.
REQ-023 Latency: word pushed at edge N is visible on BusMuxIn_InPort after edge N when buffer was empty; in_empty deasserts after the same edge.
REQ-024 Pointer wrap-around SHALL be transparent: ordering strictly FIFO across any number of wraps.
REQ-025 status_clr clears underflow; if a new underflow event coincides with status_clr, underflow remains set.

Reset
REQ-026 clear high at an edge: pointers 0, in_count 0, underflow 0; thus in_empty 1, in_full 0, dev_ready 1, BusMuxIn_InPort 0.
REQ-027 clear overrides any push/pop/status_clr in the same cycle; storage contents need not be reset.
REQ-028 clear mid-stream discards all held words; no held word appears on BusMuxIn_InPort after reset.

Structure
REQ-029 WORD_W default and INPORT_DEPTH constant SHALL live in the shared CPU package alongside the bus select encodings.
REQ-030 Storage and pointers SHALL be one sub-module sync_fifo (push, pop, data in/out, count); in_port_buffer adds handshake gating, zeroing of output when empty, and sticky status.

Verification
REQ-031 clear, then push 0x11,0x22,0x33,0x44 -> in_full=1, dev_ready=0, in_count=4, BusMuxIn_InPort=0x11.
REQ-032 Full, dev_valid=1 with 0x55 and in_pop=1 -> 0x55 not accepted, output 0x22, in_count=3.
REQ-033 in_count=2, push 0xA5 and pop same cycle -> in_count=2, order preserved; 10 pushes/pops across wrap return words in order.
REQ-034 Empty, in_pop=1 with push of 0x77 same cycle -> underflow=1, in_count=1, output 0x77; status_clr -> underflow=0.
REQ-035 Three words held, clear asserted with dev_valid=1 -> in_count=0, in_empty=1, BusMuxIn_InPort=0, dev_ready=1 next cycle.

Source files
------------

// File: rtl/in_port_buffer_pkg.sv
// Shared CPU constants: data word width, input-port FIFO depth and bus source select encodings.
package in_port_buffer_pkg;

  localparam int CPU_WORD_W   = 32;
  localparam int INPORT_DEPTH = 4;

  typedef enum logic [3:0] {
    BUS_SEL_NONE   = 4'd0,
    BUS_SEL_R0     = 4'd1,
    BUS_SEL_HI     = 4'd2,
    BUS_SEL_LO     = 4'd3,
    BUS_SEL_ZHIGH  = 4'd4,
    BUS_SEL_ZLOW   = 4'd5,
    BUS_SEL_PC     = 4'd6,
    BUS_SEL_MDR    = 4'd7,
    BUS_SEL_INPORT = 4'd8,
    BUS_SEL_CSIGN  = 4'd9
  } bus_sel_e;

endpackage

// File: rtl/in_port_buffer_sync_fifo.sv
// Storage plus wrapping pointers and occupancy count; read data is the entry at the read pointer.
// Caller guarantees push only when not full and pop only when not empty; one-cycle update, no internal backpressure.
module sync_fifo #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Storage is intentionally left unreset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/in_port_buffer.sv
// Input-port FIFO between an external device and the CPU bus InPort leg; first-word-fall-through, zero when empty.
// Device is backpressured by dev_ready = !in_full (never accepts while full, even on a same-cycle pop).
module in_port_buffer
  import in_port_buffer_pkg::*;
#(
  parameter int WORD_W = CPU_WORD_W,
  parameter int DEPTH  = INPORT_DEPTH
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic [WORD_W-1:0]      dev_data,
  input  logic                   dev_valid,
  output logic                   dev_ready,
  input  logic                   in_pop,
  output logic [WORD_W-1:0]      BusMuxIn_InPort,
  output logic                   in_empty,
  output logic                   in_full,
  output logic [$clog2(DEPTH):0] in_count,
  output logic                   underflow,
  input  logic                   status_clr
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              push;
  logic              pop;
  logic              pop_on_empty;
  logic [WORD_W-1:0] head;

  assign in_empty     = (in_count == '0);
  assign in_full      = (in_count == CW'(DEPTH));
  assign dev_ready    = !in_full;
  assign push         = dev_valid && dev_ready;
  assign pop          = in_pop && !in_empty;
  assign pop_on_empty = in_pop && in_empty;

  sync_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock (clock),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (dev_data),
    .rdata (head),
    .count (in_count)
  );

  assign BusMuxIn_InPort = in_empty ? '0 : head;

  // A fresh underflow event wins over a same-cycle status_clr.
  always_ff @(posedge clock) begin
    if (clear) begin
      underflow <= 1'b0;
    end else if (pop_on_empty) begin
      underflow <= 1'b1;
    end else if (status_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_in_port_buffer.sv
// Bench for in_port_buffer: queue-based reference model checked every cycle, plus literal directed expectations.
module tb_in_port_buffer;

  localparam int WORD_W = 32;
  localparam int DEPTH  = 4;

  logic              clock;
  logic              clear;
  logic [WORD_W-1:0] dev_data;
  logic              dev_valid;
  logic              dev_ready;
  logic              in_pop;
  logic [WORD_W-1:0] bus_inport;
  logic              in_empty;
  logic              in_full;
  logic [2:0]        in_count;
  logic              underflow;
  logic              status_clr;

  in_port_buffer #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .clock           (clock),
    .clear           (clear),
    .dev_data        (dev_data),
    .dev_valid       (dev_valid),
    .dev_ready       (dev_ready),
    .in_pop          (in_pop),
    .BusMuxIn_InPort (bus_inport),
    .in_empty        (in_empty),
    .in_full         (in_full),
    .in_count        (in_count),
    .underflow       (underflow),
    .status_clr      (status_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of held words plus the sticky flag.
  logic [WORD_W-1:0] q [$];
  bit m_uf = 1'b0;
  bit m_push, m_pop, m_uf_ev;

  always @(posedge clock) begin
    if (clear) begin
      q.delete();
      m_uf = 1'b0;
    end else begin
      m_push  = dev_valid && (q.size() < DEPTH);
      m_pop   = in_pop && (q.size() > 0);
      m_uf_ev = in_pop && (q.size() == 0);
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back(dev_data);
      if (m_uf_ev) m_uf = 1'b1;
      else if (status_clr) m_uf = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("m_count", 64'(in_count), 64'(q.size()));
      chk("m_empty", 64'(in_empty), 64'(q.size() == 0));
      chk("m_full",  64'(in_full),  64'(q.size() == DEPTH));
      chk("m_ready", 64'(dev_ready), 64'(q.size() != DEPTH));
      chk("m_bus",   64'(bus_inport), 64'((q.size() == 0) ? '0 : q[0]));
      chk("m_uflow", 64'(underflow), 64'(m_uf));
    end
  end

  task automatic step(input bit v, input logic [WORD_W-1:0] d, input bit p,
                      input bit sc, input bit clr);
    dev_valid  = v;
    dev_data   = d;
    in_pop     = p;
    status_clr = sc;
    clear      = clr;
    @(posedge clock);
    #2;
    dev_valid  = 1'b0;
    in_pop     = 1'b0;
    status_clr = 1'b0;
    clear      = 1'b0;
  endtask

  initial begin
    clear = 1'b0; dev_data = '0; dev_valid = 1'b0; in_pop = 1'b0; status_clr = 1'b0;
    @(negedge clock);

    // Reset state
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk("rst_count", 64'(in_count), 64'd0);
    chk("rst_empty", 64'(in_empty), 64'd1);
    chk("rst_full",  64'(in_full),  64'd0);
    chk("rst_ready", 64'(dev_ready), 64'd1);
    chk("rst_bus",   64'(bus_inport), 64'd0);
    chk("rst_uflow", 64'(underflow), 64'd0);

    // Fill to full; first word falls through immediately
    step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    chk("fwft_bus", 64'(bus_inport), 64'h11);
    chk("fwft_empty", 64'(in_empty), 64'd0);
    step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    chk("full_flag",  64'(in_full),  64'd1);
    chk("full_ready", 64'(dev_ready), 64'd0);
    chk("full_count", 64'(in_count), 64'd4);
    chk("full_bus",   64'(bus_inport), 64'h11);

    // Push while full with simultaneous pop is refused
    step(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    chk("fullpop_bus",   64'(bus_inport), 64'h22);
    chk("fullpop_count", 64'(in_count), 64'd3);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drain_33", 64'(bus_inport), 64'h33);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drain_44", 64'(bus_inport), 64'h44);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drain_count", 64'(in_count), 64'd0);
    chk("drain_bus",   64'(bus_inport), 64'd0);

    // Simultaneous push/pop at count 2
    step(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA5, 1'b1, 1'b0, 1'b0);
    chk("pp_count", 64'(in_count), 64'd2);
    chk("pp_bus",   64'(bus_inport), 64'hA2);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("pp_next", 64'(bus_inport), 64'hA5);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Ten words streamed through, wrapping the pointers several times
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'hC0 + 32'(i), (i >= 2), 1'b0, 1'b0);
    end
    chk("wrap_count", 64'(in_count), 64'd2);
    chk("wrap_bus",   64'(bus_inport), 64'hC8);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("wrap_last", 64'(bus_inport), 64'hC9);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("wrap_empty", 64'(in_empty), 64'd1);

    // Pop on empty with same-cycle push: underflow set, push still lands
    step(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    chk("uf_flag",  64'(underflow), 64'd1);
    chk("uf_count", 64'(in_count), 64'd1);
    chk("uf_bus",   64'(bus_inport), 64'h77);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("uf_clr", 64'(underflow), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("uf_vs_clr", 64'(underflow), 64'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("uf_clr2", 64'(underflow), 64'd0);

    // Clear mid-stream discards held words and beats a same-cycle push
    step(1'b1, 32'hD1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hD2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hD3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hD4, 1'b0, 1'b0, 1'b0);
    chk("pre_clr_count", 64'(in_count), 64'd3);
    step(1'b1, 32'h99, 1'b0, 1'b0, 1'b1);
    chk("clr_count", 64'(in_count), 64'd0);
    chk("clr_empty", 64'(in_empty), 64'd1);
    chk("clr_bus",   64'(bus_inport), 64'd0);
    chk("clr_ready", 64'(dev_ready), 64'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hE0, 1'b0, 1'b0, 1'b0);
    chk("post_clr_bus", 64'(bus_inport), 64'hE0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
